// File: rtl/pc_sequencer.sv
// PC sequencer: selects the next fetch address and drives IF flush / ID bubble controls.
// Optional statistics counters are built when PC_SEQ_STATS_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        mem_stall_i,
    input  logic        load_use_i,
    input  logic        branch_i,
    input  logic [31:0] branch_tgt_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_o,
    output logic        if_flush_o,
    output logic        id_bubble_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t      state;
    logic        boot_pend;
    logic        pend_vld;
    logic [31:0] pend_tgt;
    logic        active;
    logic        redirect;

    assign active   = (state != IDLE) && start_i;
    assign redirect = branch_i || pend_vld;

    // Dropping start_i behaves like IDLE immediately, even before the state register follows.
    always_comb begin
        pc_next_o   = RESET_PC;
        pc_write_o  = 1'b0;
        if_flush_o  = 1'b0;
        id_bubble_o = 1'b0;
        if (active) begin
            if (mem_stall_i) begin
                pc_next_o = pc_i;
            end else if (boot_pend) begin
                pc_write_o = 1'b1;
            end else if (redirect) begin
                pc_write_o = 1'b1;
                if_flush_o = 1'b1;
                pc_next_o  = branch_i ? branch_tgt_i : pend_tgt;
            end else if (load_use_i) begin
                pc_next_o   = pc_i;
                id_bubble_o = 1'b1;
            end else begin
                pc_write_o = 1'b1;
                pc_next_o  = pc_i + 32'd4;
            end
        end
    end

    // boot_pend survives a stall so the RESET_PC load happens on the first unstalled cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            boot_pend <= 1'b0;
            pend_vld  <= 1'b0;
            pend_tgt  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= RUN;
                        boot_pend <= 1'b1;
                    end
                end
                RUN, STALL: begin
                    if (!start_i) begin
                        state     <= IDLE;
                        boot_pend <= 1'b0;
                        pend_vld  <= 1'b0;
                    end else if (mem_stall_i) begin
                        state <= STALL;
                        if (branch_i) begin
                            pend_vld <= 1'b1;
                            pend_tgt <= branch_tgt_i;
                        end
                    end else begin
                        state <= RUN;
                        if (boot_pend) begin
                            boot_pend <= 1'b0;
                        end else if (redirect) begin
                            pend_vld <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PC_SEQ_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (active && !pc_write_o && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (if_flush_o && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after start.
REQ-002 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_i  in  1  run enable; low = halted.
REQ-005 SHALL have port mem_stall_i  in  1  data-memory or cache busy; freezes front end.
REQ-006 SHALL have port load_use_i  in  1  load-use hazard detected in ID.
REQ-007 SHALL have port branch_i  in  1  taken branch or jump resolved this cycle.
REQ-008 SHALL have port branch_tgt_i  in  32  redirect target, valid with branch_i.
REQ-009 SHALL have port pc_i  in  32  current PC register value.
REQ-010 SHALL have port pc_next_o  out  32  value to load into PC register.
REQ-011 SHALL have port pc_write_o  out  1  PC register load enable.
REQ-012 SHALL have port if_flush_o  out  1  squash IF/ID instruction.
REQ-013 SHALL have port id_bubble_o  out  1  insert bubble into ID/EX.
REQ-014 SHALL have ports stall_cnt_o and flush_cnt_o  out  32 each  statistics counters.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, STALL; pending register pend_vld (1 bit) and pend_tgt (32 bits).
REQ-016 IDLE SHALL drive pc_write_o=0, pc_next_o=RESET_PC, all flush/bubble outputs 0; start_i=1 sampled -> RUN.
REQ-017 On the first RUN cycle SHALL drive pc_write_o=1, pc_next_o=RESET_PC (one-shot boot load), then normal sequencing.
REQ-018 RUN with mem_stall_i=1 SHALL drive pc_write_o=0, if_flush_o=0, id_bubble_o=0, and go to STALL next cycle.
REQ-019 STALL SHALL hold pc_write_o=0 while mem_stall_i=1; mem_stall_i=0 -> outputs per REQ-021..023 in that same cycle and -> RUN.
REQ-020 branch_i=1 while mem_stall_i=1 SHALL set pend_vld=1, pend_tgt=branch_tgt_i; a later branch_i during the same stall overwrites pend_tgt.
REQ-021 Redirect (branch_i=1 or pend_vld=1) with mem_stall_i=0 SHALL drive pc_write_o=1, if_flush_o=1, pc_next_o=branch_tgt_i if branch_i else pend_tgt, and clear pend_vld.
REQ-022 load_use_i=1, no redirect, mem_stall_i=0 SHALL drive pc_write_o=0, id_bubble_o=1.
REQ-023 No stall, hazard or redirect SHALL drive pc_write_o=1, pc_next_o=pc_i+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-024 Priority SHALL be mem_stall_i > redirect > load_use_i > sequential; load_use_i and branch_i together yield flush with no bubble.
REQ-025 start_i=0 in RUN or STALL SHALL force IDLE next cycle and clear pend_vld; outputs in that cycle follow REQ-016.
REQ-026 All outputs SHALL be combinational from state, pending register and inputs; no output SHALL be X after reset.

Reset
REQ-027 rst_i=1 SHALL asynchronously force IDLE, pend_vld=0, pend_tgt=0, counters=0.
REQ-028 Reset mid-stall SHALL discard any pending redirect; pc_write_o=0 while rst_i=1.

Configuration
REQ-029 Macro PC_SEQ_STATS_EN defined: stall_cnt_o SHALL increment each cycle pc_write_o=0 outside IDLE, and flush_cnt_o each cycle if_flush_o=1; both saturate at 32'hFFFF_FFFF.
REQ-030 Macro PC_SEQ_STATS_EN undefined: counters SHALL NOT be built; stall_cnt_o and flush_cnt_o tied to 0.

Verification
REQ-031 Reset, start_i=1, pc_i follows pc_next_o -> pc_next_o sequence 0x0, 0x4, 0x8, pc_write_o=1 each cycle.
REQ-032 pc_i=0x100, branch_i=1, tgt=0x400, load_use_i=1 same cycle -> pc_next_o=0x400, if_flush_o=1, id_bubble_o=0.
REQ-033 mem_stall_i=1 for 3 cycles, branch_i=1 tgt=0x80 in stall cycle 2 -> pc_write_o=0 three cycles; on release pc_next_o=0x80, if_flush_o=1; stall_cnt_o=3 (stats build).
REQ-034 pc_i=0xFFFF_FFFC, no events -> pc_next_o=0x0000_0000.
REQ-035 rst_i pulse during stall with pending redirect -> IDLE, pc_write_o=0; after restart first pc_next_o=RESET_PC, no flush.
REQ-036 start_i dropped in RUN -> next cycle IDLE, pc_write_o=0; counters hold value (stats build) or read 0 (non-stats build).
